// File: rtl/cic_pkg.sv
// Shared CIC chain constants and the channel-index width helper used by the
// integrator, decimator and comb sections.
package cic_pkg;

    localparam int CIC_MAX_STAGES = 8;
    localparam int CIC_MAX_CH     = 16;
    localparam int CIC_MAX_M      = 4;

    // Channel index width; a single-channel build still carries a 1-bit index.
    function automatic int cic_ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: y = x - x[n-M] per channel, with per-channel M-deep
// delay storage, a registered output and valid/channel pass-through.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int OW  = 24,
    parameter int M   = 1,
    parameter int CH  = 1,
    parameter int CHW = cic_ch_width(CH)
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_valid,
    input  logic [CHW-1:0] i_ch,
    input  logic [OW-1:0]  i_data,
    output logic           o_valid,
    output logic [CHW-1:0] o_ch,
    output logic [OW-1:0]  o_data
);

    logic [OW-1:0]  dly_q [CH][M];
    logic [OW-1:0]  tap;
    logic [OW-1:0]  data_d;
    logic [OW-1:0]  data_q;
    logic [CHW-1:0] ch_q;
    logic           valid_q;

    // Select the oldest delay-line entry of the incoming sample's channel.
    always_comb begin
        tap = '0;
        for (int c = 0; c < CH; c++) begin
            if (i_ch == CHW'(c)) tap = dly_q[c][M-1];
        end
        data_d = i_data - tap;
    end

    // Register the difference and shift only the addressed channel's delay line.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            ch_q    <= '0;
            data_q  <= '0;
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < M; k++) dly_q[c][k] <= '0;
            end
        end else begin
            valid_q <= i_valid;
            if (i_valid) begin
                ch_q   <= i_ch;
                data_q <= data_d;
                for (int c = 0; c < CH; c++) begin
                    if (i_ch == CHW'(c)) begin
                        for (int k = M - 1; k > 0; k--) dly_q[c][k] <= dly_q[c][k-1];
                        dly_q[c][0] <= i_data;
                    end
                end
            end
        end
    end

    assign o_valid = valid_q;
    assign o_ch    = ch_q;
    assign o_data  = data_q;

endmodule

// File: rtl/cic_comb_cascade.sv
// Multi-channel CIC comb cascade: STAGES comb stages with differential delay M,
// time-multiplexed over CH channels. Latency is STAGES cycles, one sample/cycle.
// Build option CIC_COMB_PRIME_EN: hide each channel's first STAGES*M outputs
// (the startup transient) while still updating the delay lines.
module cic_comb_cascade
    import cic_pkg::*;
#(
    parameter int IW     = 16,
    parameter int OW     = 24,
    parameter int STAGES = 3,
    parameter int M      = 1,
    parameter int CH     = 1,
    localparam int CHW   = cic_ch_width(CH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic [CHW-1:0]       i_ch,
    input  logic signed [IW-1:0] i_data,
    output logic signed [OW-1:0] o_data,
    output logic                 o_valid,
    output logic [CHW-1:0]       o_ch
);

    logic [STAGES:0]                v_s;
    logic [STAGES:0][CHW-1:0]       ch_s;
    logic [STAGES:0][OW-1:0]        d_s;
    logic                           accept;

    // Out-of-range channel indices are dropped before touching any state.
    assign accept = i_ce && ({1'b0, i_ch} < (CHW + 1)'(CH));
    assign v_s[0]  = accept;
    assign ch_s[0] = i_ch;
    assign d_s[0]  = OW'(i_data);

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        cic_comb_stage #(
            .OW (OW),
            .M  (M),
            .CH (CH),
            .CHW(CHW)
        ) u_stage (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_valid(v_s[s]),
            .i_ch   (ch_s[s]),
            .i_data (d_s[s]),
            .o_valid(v_s[s+1]),
            .o_ch   (ch_s[s+1]),
            .o_data (d_s[s+1])
        );
    end

    assign o_data = d_s[STAGES];
    assign o_ch   = ch_s[STAGES];

`ifdef CIC_COMB_PRIME_EN
    localparam int PRIME = STAGES * M;
    localparam int PW    = $clog2(PRIME + 1);

    logic [PW-1:0] prime_q [CH];
    logic          primed;

    // Output is visible only once its channel has produced PRIME outputs.
    always_comb begin
        primed = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (ch_s[STAGES] == CHW'(c) && prime_q[c] == PW'(PRIME)) primed = 1'b1;
        end
    end

    // Count each channel's outputs, saturating at PRIME.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < CH; c++) prime_q[c] <= '0;
        end else if (v_s[STAGES]) begin
            for (int c = 0; c < CH; c++) begin
                if (ch_s[STAGES] == CHW'(c) && prime_q[c] != PW'(PRIME))
                    prime_q[c] <= prime_q[c] + 1'b1;
            end
        end
    end

    assign o_valid = v_s[STAGES] & primed;
`else
    assign o_valid = v_s[STAGES];
`endif

endmodule

// File: tb/tb_cic_comb_cascade.sv
// Scoreboard bench for cic_comb_cascade. The reference evaluates the cascade's
// closed form y[n] = sum_k (-1)^k C(STAGES,k) x[n-k*M] per channel, mod 2^OW.
module tb_cic_comb_cascade;

    localparam int IW     = 12;
    localparam int OW     = 14;
    localparam int STAGES = 3;
    localparam int M      = 2;
    localparam int CH     = 3;
    localparam int CHW    = 2;

    typedef struct {
        int            ch;
        logic [OW-1:0] data;
    } exp_t;

    logic                 i_clk = 1'b0;
    logic                 i_reset = 1'b1;
    logic                 i_ce = 1'b0;
    logic [CHW-1:0]       i_ch = '0;
    logic signed [IW-1:0] i_data = '0;
    logic signed [OW-1:0] o_data;
    logic                 o_valid;
    logic [CHW-1:0]       o_ch;

    exp_t exp_q [$];
    int   hist [CH][$];
    int   seen [CH];
    int   checks = 0;
    int   failures = 0;

    cic_comb_cascade #(
        .IW(IW), .OW(OW), .STAGES(STAGES), .M(M), .CH(CH)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_ce   (i_ce),
        .i_ch   (i_ch),
        .i_data (i_data),
        .o_data (o_data),
        .o_valid(o_valid),
        .o_ch   (o_ch)
    );

    always #5 i_clk = ~i_clk;

    function automatic int binom(input int n, input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    task automatic model_accept(input int ch, input int x);
        int   len;
        int   acc;
        int   sgn;
        exp_t e;
        hist[ch].push_back(x);
        len = hist[ch].size();
        acc = 0;
        sgn = 1;
        for (int k = 0; k <= STAGES; k++) begin
            if (len - 1 - k * M >= 0) acc += sgn * binom(STAGES, k) * hist[ch][len - 1 - k * M];
            sgn = -sgn;
        end
        e.ch   = ch;
        e.data = acc[OW-1:0];
`ifdef CIC_COMB_PRIME_EN
        if (seen[ch] < STAGES * M) seen[ch]++;
        else exp_q.push_back(e);
`else
        exp_q.push_back(e);
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int c = 0; c < CH; c++) begin
            hist[c].delete();
            seen[c] = 0;
        end
    endtask

    task automatic send(input bit ce, input int ch, input int val);
        @(posedge i_clk);
        #1;
        i_ce   = ce;
        i_ch   = CHW'(ch);
        i_data = IW'(val);
        if (ce && ch < CH) model_accept(ch, int'(i_data));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 0, 0);
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        i_ce    = 1'b0;
        model_reset();
        repeat (cycles) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    // Monitor: reset values while in reset, otherwise pop and compare on o_valid.
    always @(negedge i_clk) begin
        if (i_reset) begin
            checks++;
            if (o_valid !== 1'b0 || o_data !== '0 || o_ch !== '0) begin
                failures++;
                $display("FAIL reset_state: got valid=%0b data=%0d ch=%0d, want 0/0/0",
                         o_valid, o_data, o_ch);
            end
        end else if (o_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got ch=%0d data=%0d, want no output",
                         o_ch, o_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (o_data !== e.data || int'(o_ch) != e.ch) begin
                    failures++;
                    $display("FAIL output: got ch=%0d data=%0d, want ch=%0d data=%0d",
                             o_ch, o_data, e.ch, $signed(e.data));
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Impulse on ch0 then zeros
        send(1'b1, 0, 1);
        for (int i = 0; i < 9; i++) send(1'b1, 0, 0);
        idle(2);

        // Constant input on ch1
        for (int i = 0; i < 10; i++) send(1'b1, 1, 5);

        // Full-scale extremes on ch2 force wrap in the OW-bit arithmetic
        for (int i = 0; i < 8; i++) send(1'b1, 2, (i % 2 == 0) ? -2048 : 2047);

        // Out-of-range channel interleaved with valid traffic
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 3, 777);
            send(1'b1, i % CH, i * 100 - 250);
        end
        idle(STAGES + 2);

        // Randomised traffic with bubbles and occasional bad channel
        for (int i = 0; i < 500; i++) begin
            send($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                 int'($urandom_range(0, 4095)) - 2048);
        end

        // Reset with two samples in flight, then a fresh impulse
        send(1'b1, 0, 300);
        send(1'b1, 1, -300);
        pulse_reset(2);
        send(1'b1, 0, 1);
        for (int i = 0; i < 9; i++) send(1'b1, 0, 0);

        // Drain and confirm every expected output arrived
        idle(STAGES + 4);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d outputs still pending, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic_comb_cascade.md
# cic_comb_cascade

Parametrised, multi-channel CIC comb section: a cascade of STAGES comb stages, each computing y[n] = x[n] − x[n−M] per channel, with time-multiplexed channels sharing one datapath. It sits after the decimator in the CIC chain, consuming one sample per i_ce strobe, tagged with its channel index. It replaces the single-stage, single-channel, fixed-delay comb with a configurable depth (STAGES), differential delay (M) and channel count (CH), plus valid/channel sideband.

## Interface
- IW, 16: input sample width, signed two's complement.
- OW, 24: internal and output width, signed; OW ≥ IW.
- STAGES, 3: number of cascaded comb stages, 1..8.
- M, 1: differential delay in samples per channel, 1..4.
- CH, 1: number of time-multiplexed channels, 1..16.
- i_clk  in  1  clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_ce  in  1  input sample strobe; one sample per asserted cycle.
- i_ch  in  max(1,$clog2(CH))  channel index of i_data.
- i_data  in  IW  signed input sample.
- o_data  out  OW  signed comb output.
- o_valid  out  1  o_data/o_ch valid this cycle (single-cycle pulse per sample).
- o_ch  out  max(1,$clog2(CH))  channel index of o_data.

## Operation
- Input sign-extended from IW to OW at stage 0; all stage arithmetic in OW bits, modulo 2^OW (wrap, no saturation); wrap is correct by CIC construction when OW is sized for the integrator growth.
- Stage s (0..STAGES−1) holds, per channel c, an M-deep delay line D[s][c][0..M−1] of OW bits.
- On a valid sample at stage s for channel c: out = x − D[s][c][M−1]; D[s][c] shifts by one with x entering at [0]. Other channels' delay lines untouched.
- Valid, channel index and data advance one stage per cycle regardless of i_ce; bubbles (i_ce low) propagate as invalid and modify no state.
- i_ce accepted every cycle; back-to-back samples of the same or different channels are legal.
- i_ch ≥ CH with i_ce high: sample dropped at input; no state change, no output.
- Reset: o_data = 0, o_valid = 0, o_ch = 0, all delay lines = 0, all pipeline valids = 0, priming counters = 0. Reset mid-stream discards in-flight samples; first post-reset output behaves as from a fresh start.

## Timing
- Latency: STAGES cycles from i_ce sample to its o_valid pulse; fixed, no stall, throughput one sample per cycle.
- Every stage output registered; critical path is one OW-bit subtract plus delay-line read mux.
- Output order equals input order; o_ch echoes the accepted i_ch.

## Configuration
- CIC_COMB_PRIME_EN defined: per-channel counter counts accepted samples up to STAGES·M; o_valid suppressed for that channel's first STAGES·M outputs (startup transient hidden), state still updated. Counters cleared by reset only; saturate at STAGES·M.
- Undefined: no counter; o_valid asserted for every accepted sample from the first, transient included (delay lines start at zero).

## Structure
- Package cic_pkg: CIC_MAX_STAGES, CIC_MAX_CH, CIC_MAX_M constants, and the channel-index width function shared with the integrator and decimator.
- Sub-module cic_comb_stage: one stage (per-channel M-deep delay storage, subtract, output register, valid/channel pass-through); top instantiates STAGES copies in a generate loop and holds the priming logic.

## Test plan
- STAGES=3, M=1, CH=1, impulse 1 then zeros, i_ce every cycle -> after 3 cycles outputs 1, −3, 3, −1, 0, 0.
- Same config, constant input 5 -> outputs 5, −10, 5, 0, 0 … (steady state 0).
- STAGES=1, M=2, CH=2, interleaved ch0 = 1,2,3,4 and ch1 = 10,20,30,40 -> ch0 out 1,2,2,2; ch1 out 10,20,20,20; o_ch alternates 0,1.
- IW=8, OW=8, STAGES=1, M=1, inputs −128 then 127 -> outputs −128, then 127−(−128) wraps to −1.
- Reset asserted mid-stream with 2 samples in flight -> o_valid low next cycle, in-flight outputs never appear; impulse after release reproduces the first scenario exactly.
- CIC_COMB_PRIME_EN, STAGES=2, M=2, CH=1, 6 samples -> first 4 produce no o_valid, samples 5–6 produce o_valid; i_ch = CH with i_ce -> no output.
